// File: rtl/sim_page_writer.sv
// Simulated-data DDR page writer: a run of command + PAGE_WORDS data bursts.
// Optional macro SIM_PAGE_WRITER_CHECKSUM_EN builds the 32-bit run checksum.
module sim_page_writer #(
  parameter int DATA_W     = 64,
  parameter int PAGE_WORDS = 256,
  parameter int ADDR_W     = 32
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              MEM_WEN,
  input  logic              PATTERN_EN,
  input  logic [1:0]        PATTERN,
  input  logic [31:0]       WRITE_PAGE_NO,
  output logic              CMD_VALID,
  input  logic              CMD_READY,
  output logic [ADDR_W-1:0] CMD_ADDR,
  output logic              DATA_VALID,
  input  logic              DATA_READY,
  output logic [DATA_W-1:0] DATA,
  output logic              DATA_LAST,
  output logic              BUSY,
  output logic              DONE,
  output logic [31:0]       PAGES_WRITTEN,
  output logic [31:0]       RUN_CHECKSUM
);
  localparam int WW = $clog2(PAGE_WORDS);
  localparam logic [63:0] PAGE_BYTES = 64'(PAGE_WORDS) * 64'(DATA_W / 8);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_DATA, S_FIN, S_WAIT_LOW} state_t;

  state_t            state_q;
  logic              pat_en_q;
  logic [1:0]        pat_q;
  logic [31:0]       target_q, page_q, beat_q, pages_q;
  logic [WW-1:0]     word_q, word_d;
  logic [31:0]       beat_d;
  logic              cmd_valid_q, data_valid_q, last_q, last_d, busy_q, done_q;
  logic [ADDR_W-1:0] cmd_addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              beat_acc;

  function automatic logic [DATA_W-1:0] pat_word(input logic en, input logic [1:0] sel,
      input logic [31:0] page, input logic [WW-1:0] word, input logic [31:0] cnt);
    logic [DATA_W-1:0] w;
    w = '0;
    if (en) begin
      case (sel)
        2'd0: w[31:0] = cnt;
        2'd1: begin w[63:32] = page; w[31:0] = 32'(word); end
        2'd2: w = {{(DATA_W-1){1'b0}}, 1'b1} << (32'(word) % 32'(DATA_W));
        default: for (int i = 0; i < DATA_W; i++) w[i] = word[0] ^ i[0];
      endcase
    end
    return w;
  endfunction

  // word/beat counters advance on acceptance; the payload is always
  // pre-computed for the beat that will be presented next.
  always_comb begin
    beat_acc = data_valid_q & DATA_READY;
    word_d   = word_q + WW'(beat_acc);
    beat_d   = beat_q + 32'(beat_acc);
    last_d   = (word_d == WW'(PAGE_WORDS - 1));
    data_d   = pat_word(pat_en_q, pat_q, page_q, word_d, beat_d);
    addr_d   = ADDR_W'(64'(page_q) * PAGE_BYTES);
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q      <= S_IDLE;
      pat_en_q     <= 1'b0;
      pat_q        <= '0;
      target_q     <= '0;
      page_q       <= '0;
      word_q       <= '0;
      beat_q       <= '0;
      pages_q      <= '0;
      cmd_valid_q  <= 1'b0;
      cmd_addr_q   <= '0;
      data_valid_q <= 1'b0;
      data_q       <= '0;
      last_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (MEM_WEN) begin
          pat_en_q <= PATTERN_EN;
          pat_q    <= PATTERN;
          target_q <= WRITE_PAGE_NO;
          page_q   <= '0;
          word_q   <= '0;
          beat_q   <= '0;
          pages_q  <= '0;
          if (WRITE_PAGE_NO == 32'd0) state_q <= S_FIN;
          else begin
            state_q <= S_CMD;
            busy_q  <= 1'b1;
          end
        end
        S_CMD: begin
          if (!cmd_valid_q) begin
            cmd_valid_q <= 1'b1;
            cmd_addr_q  <= addr_d;
          end else if (CMD_READY) begin
            cmd_valid_q  <= 1'b0;
            data_valid_q <= 1'b1;
            data_q       <= data_d;
            last_q       <= last_d;
            state_q      <= S_DATA;
          end
        end
        S_DATA: if (beat_acc) begin
          word_q <= word_d;
          beat_q <= beat_d;
          if (last_q) begin
            data_valid_q <= 1'b0;
            last_q       <= 1'b0;
            pages_q      <= pages_q + 32'd1;
            page_q       <= page_q + 32'd1;
            // abort is only honoured at a page boundary
            if ((pages_q + 32'd1 == target_q) || !MEM_WEN) begin
              state_q <= S_FIN;
              busy_q  <= 1'b0;
            end else state_q <= S_CMD;
          end else begin
            data_q <= data_d;
            last_q <= last_d;
          end
        end
        S_FIN: begin
          done_q  <= 1'b1;
          state_q <= S_WAIT_LOW;
        end
        S_WAIT_LOW: if (!MEM_WEN) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef SIM_PAGE_WRITER_CHECKSUM_EN
  logic [31:0] sum_q;
  always_ff @(posedge CLK) begin
    if (!RESET_N) sum_q <= '0;
    else if (state_q == S_IDLE && MEM_WEN) sum_q <= '0;
    else if (beat_acc) sum_q <= sum_q + data_q[31:0];
  end
  assign RUN_CHECKSUM = sum_q;
`else
  assign RUN_CHECKSUM = '0;
`endif

  assign CMD_VALID     = cmd_valid_q;
  assign CMD_ADDR      = cmd_addr_q;
  assign DATA_VALID    = data_valid_q;
  assign DATA          = data_q;
  assign DATA_LAST     = last_q;
  assign BUSY          = busy_q;
  assign DONE          = done_q;
  assign PAGES_WRITTEN = pages_q;
endmodule

// File: doc/sim_page_writer.md
# sim_page_writer

Sequencer that drives simulated-data page writes into DDR for the ROC test path. It consumes the already-muxed simulation controls (`MEM_WEN`, `PATTERN_EN`, `PATTERN`, `WRITE_PAGE_NO`) and turns them into a run of page-sized write bursts. Each burst is a command beat followed by `PAGE_WORDS` data beats on a valid/ready write interface toward the DDR write port. It reports progress and completion back to DCS/serial status registers.

## Interface

Parameters:

- `DATA_W`, 64: data beat width in bits; must be ≥ 64.
- `PAGE_WORDS`, 256: beats per page; power of 2, ≥ 2.
- `ADDR_W`, 32: byte address width.

Ports:

- `CLK`  in  1  system clock; single clock domain.
- `RESET_N`  in  1  synchronous, active-low reset.
- `MEM_WEN`  in  1  run request, level.
- `PATTERN_EN`  in  1  1 = pattern data, 0 = all-zero data.
- `PATTERN`  in  2  pattern select.
- `WRITE_PAGE_NO`  in  32  number of pages in the run.
- `CMD_VALID`  out  1  page write command valid.
- `CMD_READY`  in  1  command accepted.
- `CMD_ADDR`  out  ADDR_W  page byte address.
- `DATA_VALID`  out  1  data beat valid.
- `DATA_READY`  in  1  data beat accepted.
- `DATA`  out  DATA_W  beat payload.
- `DATA_LAST`  out  1  final beat of the page.
- `BUSY`  out  1  run in progress (states CMD or DATA).
- `DONE`  out  1  one-cycle pulse at run end.
- `PAGES_WRITTEN`  out  32  pages completed in the current or last run.
- `RUN_CHECKSUM`  out  32  see Configuration.

## Operation

- FSM states: IDLE, CMD, DATA, FIN, WAIT_LOW.
- **IDLE:**
  - On `MEM_WEN`=1, latch `PATTERN_EN`, `PATTERN` and `WRITE_PAGE_NO` into shadow registers.
  - Clear the page index, the word index, the global beat counter, `PAGES_WRITTEN` and the checksum.
  - Go to FIN if the latched page count is 0, otherwise to CMD.
- **CMD:**
  - `CMD_VALID`=1; `CMD_ADDR` = page_idx × PAGE_WORDS × DATA_W/8, truncated to ADDR_W. Address wraps modulo 2^ADDR_W.
  - On `CMD_READY`, go to DATA with word_idx=0.
- **DATA:**
  - `DATA_VALID`=1; `DATA_LAST`=1 when word_idx = PAGE_WORDS−1.
  - Each accepted beat (VALID & READY) increments word_idx and the beat counter.
  - On the accepted last beat:
    - `PAGES_WRITTEN` and page_idx increment.
    - If `PAGES_WRITTEN`+1 = target, or `MEM_WEN`=0, go to FIN; else go to CMD.
- **FIN:** `DONE`=1 for this single cycle, then go to WAIT_LOW.
- **WAIT_LOW:** return to IDLE once `MEM_WEN`=0. A level held high never starts a second run.
- **Abort:** `MEM_WEN` falling mid-run never truncates a page. The current page completes, then the FSM goes to FIN.
- **Pattern data** (all outputs zero-extended to DATA_W):
  - `PATTERN_EN`=0: all zeros.
  - `PATTERN` 0: global beat counter, 32 bits.
  - `PATTERN` 1: {page_idx[31:0], 32'(word_idx)}.
  - `PATTERN` 2: 1 << (word_idx mod DATA_W).
  - `PATTERN` 3: 0xAAAA… when word_idx is even, 0x5555… when odd.
- **Input stability:** input changes during a run are ignored except for `MEM_WEN`.
- **Reset values:** all outputs 0; state IDLE.

## Timing

- `MEM_WEN` sampled high in IDLE at edge k → `CMD_VALID`=1 after edge k+1.
- `DATA` and `DATA_LAST` are registered and held stable while VALID=1 and READY=0.
- No bubbles between beats when `DATA_READY` is held at 1: one beat per cycle.
- Last beat accepted at edge k → next `CMD_VALID` high after edge k+1, or `DONE` high after edge k+1.
- `PAGES_WRITTEN` updates on the same edge that accepts the last beat.
- Zero-page run: `MEM_WEN` sampled at edge k → `DONE` after edge k+1. No `CMD_VALID` is issued.
- Reset asserted mid-run (`RESET_N`=0 at edge k) → all outputs 0 after edge k, even if a handshake is open.
- Minimum page time is PAGE_WORDS+2 cycles.

## Configuration

- Macro: `SIM_PAGE_WRITER_CHECKSUM_EN`.
- **Defined:**
  - `RUN_CHECKSUM` = sum modulo 2^32 of `DATA[31:0]` over every accepted beat of the run.
  - Cleared when the run starts and held after `DONE`.
- **Undefined:** `RUN_CHECKSUM` is tied to 0 and no adder logic is built.

## Test plan

- **Single page, counter pattern.** WRITE_PAGE_NO=1, PATTERN_EN=1, PATTERN=0, READY held at 1.
  - One command at address 0x0.
  - 256 beats with DATA 0..255 and DATA_LAST on beat 255.
  - DONE after 259 cycles total from start; PAGES_WRITTEN=1.
  - RUN_CHECKSUM=32640 when the macro is defined.
- **Three pages, stamp pattern.** PATTERN=1, READY toggling 50%.
  - CMD_ADDR 0x0, 0x800, 0x1000.
  - Page 2, word 5 carries DATA=0x00000002_00000005.
  - DATA stays stable during every stall.
- **Zero-page run.** WRITE_PAGE_NO=0.
  - DONE one cycle after the start sample; CMD_VALID never asserts.
- **Mid-run abort.** WRITE_PAGE_NO=10; drop MEM_WEN during page 3 (page_idx=3).
  - Page 3 completes with all 256 beats, then DONE; PAGES_WRITTEN=4.
- **Held level.** MEM_WEN held high after DONE.
  - No second CMD_VALID is issued.
  - After MEM_WEN goes low then high again, a new run starts and PAGES_WRITTEN is cleared.
- **Reset mid-burst.** Assert RESET_N=0 during DATA, then release.
  - All outputs 0 and the FSM is in IDLE; the next run behaves normally.
  - PATTERN_EN=0 in that run gives all-zero DATA.
